// File: rtl/avmm_csr_responder.sv
// Avalon-MM CSR responder: single-transfer FSM with programmable wait states,
// fixed-latency read return pipeline and a bank of byte-writable registers.
module avmm_csr_responder #(
   parameter int unsigned           AVMM_WIDTH    = 32,
   parameter int unsigned           BYTE_WIDTH    = 4,
   parameter int unsigned           NUM_REGS      = 8,
   parameter int unsigned           WAIT_CYCLES   = 1,
   parameter int unsigned           READ_LATENCY  = 2,
   parameter logic [AVMM_WIDTH-1:0] ID_VALUE      = 32'h0000_A1B2,
   parameter logic [AVMM_WIDTH-1:0] BAD_ADDR_DATA = 32'hDEAD_BEEF
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [16:0]                    address,
   input  logic                           read,
   input  logic                           write,
   input  logic [AVMM_WIDTH-1:0]          writedata,
   input  logic [BYTE_WIDTH-1:0]          byteenable,
   output logic [AVMM_WIDTH-1:0]          readdata,
   output logic                           readdatavalid,
   output logic                           waitrequest,
   output logic [NUM_REGS*AVMM_WIDTH-1:0] csr_out
);

   localparam int unsigned IDX_W  = 15;
   localparam int unsigned SEL_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int unsigned PIPE_W = READ_LATENCY * AVMM_WIDTH;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCEPT} state_t;

   state_t                  state, state_nxt;
   logic                    waitrequest_nxt;
   logic [3:0]              wait_cnt;
   logic                    req;
   logic                    lat_wr, lat_rd;
   logic [IDX_W-1:0]        lat_idx;
   logic [AVMM_WIDTH-1:0]   lat_data;
   logic [BYTE_WIDTH-1:0]   lat_be;
   logic [SEL_W-1:0]        sel;
   logic                    idx_in_range;
   logic                    accept_wr, accept_rd, wr_hit;
   logic [AVMM_WIDTH-1:0]   wmask, rd_word, rd_ret;
   logic [READ_LATENCY-1:0] pipe_v;
   logic [PIPE_W-1:0]       pipe_d;
   logic                    unused_addr_lsbs;

   assign req              = read | write;
   assign unused_addr_lsbs = ^address[1:0];
   assign sel              = lat_idx[SEL_W-1:0];
   assign idx_in_range     = lat_idx < IDX_W'(NUM_REGS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         waitrequest <= 1'b1;
      end else begin
         state       <= state_nxt;
         waitrequest <= waitrequest_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (req) state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCEPT;
         ST_WAIT: begin
            if (!req)                 state_nxt = ST_IDLE;
            else if (wait_cnt <= 4'd1) state_nxt = ST_ACCEPT;
         end
         ST_ACCEPT: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      waitrequest_nxt = (state_nxt != ST_ACCEPT);
      accept_wr       = (state == ST_ACCEPT) && lat_wr;
      accept_rd       = (state == ST_ACCEPT) && lat_rd;
      wr_hit          = accept_wr && idx_in_range;
   end

   // Command is captured once in IDLE; a simultaneous read+write is kept as a write only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
         lat_wr   <= 1'b0;
         lat_rd   <= 1'b0;
         lat_idx  <= '0;
         lat_data <= '0;
         lat_be   <= '0;
      end else if (state == ST_IDLE) begin
         wait_cnt <= req ? 4'(WAIT_CYCLES) : '0;
         if (req) begin
            lat_wr   <= write;
            lat_rd   <= read & ~write;
            lat_idx  <= address[16:2];
            lat_data <= writedata;
            lat_be   <= byteenable;
         end
      end else if (state == ST_WAIT) begin
         wait_cnt <= wait_cnt - 4'd1;
      end else begin
         wait_cnt <= '0;
      end
   end

   for (genvar b = 0; b < BYTE_WIDTH; b++) begin : g_wmask
      assign wmask[b*8 +: 8] = {8{lat_be[b]}};
   end

   assign csr_out[0 +: AVMM_WIDTH] = ID_VALUE;

   for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
      logic [AVMM_WIDTH-1:0] q;
      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            q <= '0;
         else if (wr_hit && (sel == SEL_W'(g)))
            q <= (q & ~wmask) | (lat_data & wmask);
      end
      assign csr_out[g*AVMM_WIDTH +: AVMM_WIDTH] = q;
   end

   // Slot 0 of csr_out already carries ID_VALUE, so one indexed select covers every in-range read.
   always_comb begin
      rd_word = idx_in_range ? csr_out[sel*AVMM_WIDTH +: AVMM_WIDTH] : BAD_ADDR_DATA;
      rd_ret  = accept_rd ? rd_word : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_v <= '0;
         pipe_d <= '0;
      end else begin
         pipe_v <= READ_LATENCY'({pipe_v, accept_rd});
         pipe_d <= PIPE_W'({pipe_d, rd_ret});
      end
   end

   assign readdatavalid = pipe_v[READ_LATENCY-1];
   assign readdata      = pipe_d[PIPE_W-1 -: AVMM_WIDTH];

endmodule

// File: tb/tb_avmm_csr_responder.sv
// Directed bench for avmm_csr_responder: three instances cover different
// wait-state / read-latency settings; vectors carry hand-computed expectations.
module tb_avmm_csr_responder;

   localparam logic [255:0] RESET_CSR = 256'h0000_A1B2;
   localparam int NV = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [16:0] address    [3];
   logic        rd_req     [3];
   logic        wr_req     [3];
   logic [31:0] writedata  [3];
   logic [3:0]  byteenable [3];
   logic [31:0] readdata   [3];
   logic        readdatavalid [3];
   logic        waitrequest   [3];
   logic [255:0] csr_out      [3];

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;
   int idle_errs = 0;

   typedef struct {
      int          cyc;
      logic [31:0] data;
   } ret_t;
   ret_t rq0[$], rq1[$], rq2[$];

   typedef struct {
      bit          wr;
      bit          rd;
      logic [16:0] addr;
      logic [31:0] wd;
      logic [3:0]  be;
      logic [31:0] exp_rd;
      int          slot;
      logic [31:0] slot_exp;
   } vec_t;
   vec_t vecs [NV];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   avmm_csr_responder #(.AVMM_WIDTH(32), .BYTE_WIDTH(4), .NUM_REGS(8), .WAIT_CYCLES(1),
      .READ_LATENCY(2), .ID_VALUE(32'h0000_A1B2), .BAD_ADDR_DATA(32'hDEAD_BEEF)) u_dut_a (
      .clk(clk), .rst(rst), .address(address[0]), .read(rd_req[0]), .write(wr_req[0]),
      .writedata(writedata[0]), .byteenable(byteenable[0]), .readdata(readdata[0]),
      .readdatavalid(readdatavalid[0]), .waitrequest(waitrequest[0]), .csr_out(csr_out[0]));

   avmm_csr_responder #(.AVMM_WIDTH(32), .BYTE_WIDTH(4), .NUM_REGS(8), .WAIT_CYCLES(0),
      .READ_LATENCY(4), .ID_VALUE(32'h0000_A1B2), .BAD_ADDR_DATA(32'hDEAD_BEEF)) u_dut_b (
      .clk(clk), .rst(rst), .address(address[1]), .read(rd_req[1]), .write(wr_req[1]),
      .writedata(writedata[1]), .byteenable(byteenable[1]), .readdata(readdata[1]),
      .readdatavalid(readdatavalid[1]), .waitrequest(waitrequest[1]), .csr_out(csr_out[1]));

   avmm_csr_responder #(.AVMM_WIDTH(32), .BYTE_WIDTH(4), .NUM_REGS(8), .WAIT_CYCLES(3),
      .READ_LATENCY(3), .ID_VALUE(32'h0000_A1B2), .BAD_ADDR_DATA(32'hDEAD_BEEF)) u_dut_c (
      .clk(clk), .rst(rst), .address(address[2]), .read(rd_req[2]), .write(wr_req[2]),
      .writedata(writedata[2]), .byteenable(byteenable[2]), .readdata(readdata[2]),
      .readdatavalid(readdatavalid[2]), .waitrequest(waitrequest[2]), .csr_out(csr_out[2]));

   always @(negedge clk) begin
      if (readdatavalid[0]) rq0.push_back('{cyc, readdata[0]});
      if (readdatavalid[1]) rq1.push_back('{cyc, readdata[1]});
      if (readdatavalid[2]) rq2.push_back('{cyc, readdata[2]});
      for (int d = 0; d < 3; d++)
         if (!readdatavalid[d] && readdata[d] !== 32'h0) idle_errs++;
   end

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic check256(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Called just after a rising edge; returns the negedge index of the accept cycle and its cycle number.
   task automatic xfer(input int d, input bit wr, input bit rd, input logic [16:0] a,
                       input logic [31:0] wd, input logic [3:0] be, output int k, output int acc);
      address[d] = a; writedata[d] = wd; byteenable[d] = be;
      wr_req[d] = wr; rd_req[d] = rd;
      k = -1; acc = -1;
      for (int i = 0; i < 40 && k < 0; i++) begin
         @(negedge clk);
         if (!waitrequest[d]) begin
            k = i;
            acc = cyc;
         end
      end
      if (k < 0) begin
         n_tests++; n_fail++;
         $display("FAIL accept_timeout dut%0d: waitrequest never low, required low within 40 cycles", d);
      end
      @(posedge clk); #1;
      wr_req[d] = 1'b0; rd_req[d] = 1'b0;
   endtask

   task automatic expect_ret(input int d, input int acc, input int lat, input logic [31:0] exp,
                             input string name);
      ret_t r;
      int   sz;
      for (int i = 0; i < 64 && cyc <= acc + lat; i++) @(negedge clk);
      case (d)
         0: sz = rq0.size();
         1: sz = rq1.size();
         default: sz = rq2.size();
      endcase
      if (sz == 0) begin
         n_tests++; n_fail++;
         $display("FAIL %s: got no readdatavalid pulse, required one at cycle %0d", name, acc + lat);
      end else begin
         case (d)
            0: r = rq0.pop_front();
            1: r = rq1.pop_front();
            default: r = rq2.pop_front();
         endcase
         check32({name, "_cycle"}, r.cyc, acc + lat);
         check32({name, "_data"}, r.data, exp);
      end
   endtask

   initial begin
      int k, acc, acc1, acc2, acc3, lows;
      vec_t v;

      for (int d = 0; d < 3; d++) begin
         address[d] = '0; rd_req[d] = 1'b0; wr_req[d] = 1'b0;
         writedata[d] = '0; byteenable[d] = '0;
      end

      vecs[0]  = '{1'b0, 1'b1, 17'h00000, 32'h0,         4'h0, 32'h0000_A1B2, 0, 32'h0000_A1B2};
      vecs[1]  = '{1'b1, 1'b0, 17'h0000C, 32'h1234_5678, 4'hF, 32'h0,         3, 32'h1234_5678};
      vecs[2]  = '{1'b1, 1'b0, 17'h0000C, 32'hAAAA_AAAA, 4'h5, 32'h0,         3, 32'h12AA_56AA};
      vecs[3]  = '{1'b0, 1'b1, 17'h0000C, 32'h0,         4'h0, 32'h12AA_56AA, 3, 32'h12AA_56AA};
      vecs[4]  = '{1'b1, 1'b0, 17'h00000, 32'hFFFF_FFFF, 4'hF, 32'h0,         0, 32'h0000_A1B2};
      vecs[5]  = '{1'b1, 1'b0, 17'h00024, 32'hFFFF_FFFF, 4'hF, 32'h0,         1, 32'h0};
      vecs[6]  = '{1'b0, 1'b1, 17'h00000, 32'h0,         4'h0, 32'h0000_A1B2, 0, 32'h0000_A1B2};
      vecs[7]  = '{1'b0, 1'b1, 17'h00024, 32'h0,         4'h0, 32'hDEAD_BEEF, 1, 32'h0};
      vecs[8]  = '{1'b0, 1'b1, 17'h00020, 32'h0,         4'h0, 32'hDEAD_BEEF, 7, 32'h0};
      vecs[9]  = '{1'b1, 1'b0, 17'h0001C, 32'hCAFE_0000, 4'hC, 32'h0,         7, 32'hCAFE_0000};
      vecs[10] = '{1'b0, 1'b1, 17'h0001C, 32'h0,         4'h0, 32'hCAFE_0000, 7, 32'hCAFE_0000};
      vecs[11] = '{1'b1, 1'b1, 17'h00014, 32'h0000_00C3, 4'h1, 32'h0,         5, 32'h0000_00C3};
      vecs[12] = '{1'b1, 1'b0, 17'h00008, 32'h0000_0055, 4'hF, 32'h0,         2, 32'h0000_0055};
      vecs[13] = '{1'b0, 1'b1, 17'h00008, 32'h0,         4'h0, 32'h0000_0055, 2, 32'h0000_0055};
      vecs[14] = '{1'b0, 1'b1, 17'h0000E, 32'h0,         4'h0, 32'h12AA_56AA, 3, 32'h12AA_56AA};
      vecs[15] = '{1'b0, 1'b1, 17'h1FFFC, 32'h0,         4'h0, 32'hDEAD_BEEF, 3, 32'h12AA_56AA};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check32("rst_waitrequest", 32'(waitrequest[0]), 32'd1);
      check32("rst_readdatavalid", 32'(readdatavalid[0]), 32'd0);
      check32("rst_readdata", readdata[0], 32'h0);
      check256("rst_csr_out_a", csr_out[0], RESET_CSR);
      check256("rst_csr_out_c", csr_out[2], RESET_CSR);
      @(posedge clk); #1;

      for (int i = 0; i < NV; i++) begin
         v = vecs[i];
         xfer(0, v.wr, v.rd, v.addr, v.wd, v.be, k, acc);
         check32($sformatf("v%0d_accept_lat", i), k, 32'd2);
         check32($sformatf("v%0d_csr_slot%0d", i, v.slot), csr_out[0][v.slot*32 +: 32], v.slot_exp);
         if (v.rd && !v.wr) begin
            expect_ret(0, acc, 2, v.exp_rd, $sformatf("v%0d_ret", i));
            @(posedge clk); #1;
         end else if (v.rd && v.wr) begin
            repeat (4) @(negedge clk);
            check32($sformatf("v%0d_no_rdv", i), rq0.size(), 32'd0);
            @(posedge clk); #1;
         end
      end
      check32("a_csr_reg3", csr_out[0][127:96], 32'h12AA_56AA);
      check256("a_csr_final", csr_out[0], {32'hCAFE_0000, 32'h0, 32'h0000_00C3, 32'h0,
                                           32'h12AA_56AA, 32'h0000_0055, 32'h0, 32'h0000_A1B2});

      // Zero wait states, latency 4: overlapping reads must return in order, 2 cycles apart.
      xfer(1, 1'b1, 1'b0, 17'h04, 32'h1, 4'hF, k, acc);
      check32("b_accept_lat", k, 32'd1);
      xfer(1, 1'b1, 1'b0, 17'h08, 32'h2, 4'hF, k, acc);
      xfer(1, 1'b1, 1'b0, 17'h0C, 32'h3, 4'hF, k, acc);
      xfer(1, 1'b0, 1'b1, 17'h04, 32'h0, 4'h0, k, acc1);
      xfer(1, 1'b0, 1'b1, 17'h08, 32'h0, 4'h0, k, acc2);
      xfer(1, 1'b0, 1'b1, 17'h0C, 32'h0, 4'h0, k, acc3);
      check32("b_spacing_12", acc2 - acc1, 32'd2);
      check32("b_spacing_23", acc3 - acc2, 32'd2);
      expect_ret(1, acc1, 4, 32'h1, "b_ret1");
      expect_ret(1, acc2, 4, 32'h2, "b_ret2");
      expect_ret(1, acc3, 4, 32'h3, "b_ret3");
      @(posedge clk); #1;

      // Three wait states: withdrawn write must leave no trace.
      xfer(2, 1'b1, 1'b0, 17'h10, 32'h1111_1111, 4'hF, k, acc);
      check32("c_accept_lat", k, 32'd4);
      address[2] = 17'h10; writedata[2] = 32'h2222_2222; byteenable[2] = 4'hF; wr_req[2] = 1'b1;
      @(posedge clk); #1;
      wr_req[2] = 1'b0;
      lows = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (!waitrequest[2]) lows++;
      end
      check32("c_withdraw_no_accept", lows, 32'd0);
      check32("c_withdraw_reg4", csr_out[2][159:128], 32'h1111_1111);
      @(posedge clk); #1;
      xfer(2, 1'b0, 1'b1, 17'h10, 32'h0, 4'h0, k, acc);
      check32("c_after_withdraw_lat", k, 32'd4);
      expect_ret(2, acc, 3, 32'h1111_1111, "c_ret_reg4");
      @(posedge clk); #1;

      // Reset while a read is in WAIT.
      address[2] = 17'h10; rd_req[2] = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1; rd_req[2] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (8) @(negedge clk);
      check32("rst_mid_no_rdv", rq2.size(), 32'd0);
      check32("rst_mid_waitrequest", 32'(waitrequest[2]), 32'd1);
      check256("rst_mid_csr_c", csr_out[2], RESET_CSR);
      check256("rst_mid_csr_a", csr_out[0], RESET_CSR);
      check32("readdata_idle_zero", idle_errs, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
